// File: rtl/bp_nonsynth_stall_counter_bank.sv
// Stall-profiler counter bank: per-reason, commit, cycle and bubble counters
// read over a single-outstanding valid/ready-yumi port with optional clear.
//
// Ports:
//   clk_i, reset_n_i (async, active-low)
//   freeze_i, commit_v_i, stall_reason_i : per-cycle event stream
//   rd_v_i, rd_addr_i, rd_clear_i, rd_ready_o : read request
//   rd_v_o, rd_data_o, rd_err_o, rd_yumi_i    : read response
//   overflow_o : sticky wrap flags (BP_STALL_CTR_OVERFLOW_EN only)
// Address map: 0..R-1 reason, R commit, R+1 cycle, R+2 unattributed.
// Macro BP_STALL_CTR_OVERFLOW_EN: wrapping counters plus overflow_o;
// undefined: saturating counters.
module bp_nonsynth_stall_counter_bank #(
  parameter int num_reasons_p = 16,
  parameter int ctr_width_p   = 32,
  parameter int addr_width_p  = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     freeze_i,
  input  logic                     commit_v_i,
  input  logic [num_reasons_p-1:0] stall_reason_i,
  input  logic                     rd_v_i,
  input  logic [addr_width_p-1:0]  rd_addr_i,
  input  logic                     rd_clear_i,
  output logic                     rd_ready_o,
  output logic                     rd_v_o,
  output logic [ctr_width_p-1:0]   rd_data_o,
  output logic                     rd_err_o,
`ifdef BP_STALL_CTR_OVERFLOW_EN
  output logic [num_reasons_p+2:0] overflow_o,
`endif
  input  logic                     rd_yumi_i
);

  localparam int NC = num_reasons_p + 3;
  localparam int CR = num_reasons_p;
  localparam int CY = num_reasons_p + 1;
  localparam int UN = num_reasons_p + 2;
  localparam logic [ctr_width_p-1:0] ONES = '1;

  typedef enum logic {IDLE, RESP} state_e;

  state_e                 state_q;
  logic                   rd_ready_q;
  logic                   rd_v_q;
  logic [ctr_width_p-1:0] rd_data_q;
  logic                   rd_err_q;

  logic [ctr_width_p-1:0] ctr_q [NC];
  logic [ctr_width_p-1:0] ctr_d [NC];
  logic [NC-1:0]          inc;
  logic [NC-1:0]          clr;
  logic [NC-1:0]          wrap;
  logic                   accept;
  logic                   in_range;
  logic [ctr_width_p-1:0] rd_val;

  assign accept   = rd_v_i & rd_ready_q;
  assign in_range = 32'(rd_addr_i) < NC;

  // Commit wins over reasons; bubbles with no reason are unattributed.
  always_comb begin
    inc = '0;
    if (!freeze_i) begin
      inc[CY] = 1'b1;
      if (commit_v_i) begin
        inc[CR] = 1'b1;
      end else if (|stall_reason_i) begin
        inc[num_reasons_p-1:0] = stall_reason_i;
      end else begin
        inc[UN] = 1'b1;
      end
    end
  end

  // Out-of-range addresses match nothing: data 0, no clear.
  always_comb begin
    rd_val = '0;
    clr    = '0;
    for (int k = 0; k < NC; k++) begin
      if (32'(rd_addr_i) == k) begin
        rd_val = ctr_q[k];
        clr[k] = accept & rd_clear_i;
      end
    end
  end

  // A clear restarts from 0 but still takes this cycle's event.
  always_comb begin
    wrap = '0;
    for (int k = 0; k < NC; k++) begin
      ctr_d[k] = clr[k] ? '0 : ctr_q[k];
      if (inc[k]) begin
        if (ctr_d[k] == ONES) begin
`ifdef BP_STALL_CTR_OVERFLOW_EN
          ctr_d[k] = '0;
          wrap[k]  = 1'b1;
`endif
        end else begin
          ctr_d[k] = ctr_d[k] + ctr_width_p'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < NC; k++) ctr_q[k] <= '0;
    end else begin
      for (int k = 0; k < NC; k++) ctr_q[k] <= ctr_d[k];
    end
  end

`ifdef BP_STALL_CTR_OVERFLOW_EN
  logic [NC-1:0] ovf_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~clr) | wrap;
    end
  end

  assign overflow_o = ovf_q;
`else
  logic unused_wrap;
  assign unused_wrap = |wrap;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      rd_ready_q <= 1'b1;
      rd_v_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rd_v_i) begin
            state_q    <= RESP;
            rd_ready_q <= 1'b0;
            rd_v_q     <= 1'b1;
            rd_data_q  <= rd_val;
            rd_err_q   <= ~in_range;
          end
        end
        RESP: begin
          if (rd_yumi_i) begin
            state_q    <= IDLE;
            rd_ready_q <= 1'b1;
            rd_v_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          rd_ready_q <= 1'b1;
          rd_v_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rd_ready_o = rd_ready_q;
  assign rd_v_o     = rd_v_q;
  assign rd_data_o  = rd_data_q;
  assign rd_err_o   = rd_err_q;

endmodule

// File: tb/tb_bp_nonsynth_stall_counter_bank.sv
// Directed bench for the stall counter bank.
// Narrow counters keep the saturation scenario short.
module tb_bp_nonsynth_stall_counter_bank;

  localparam int R = 16;
  localparam int W = 8;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         reset_n_i;
  logic         freeze_i;
  logic         commit_v_i;
  logic [R-1:0] stall_reason_i;
  logic         rd_v_i;
  logic [A-1:0] rd_addr_i;
  logic         rd_clear_i;
  logic         rd_ready_o;
  logic         rd_v_o;
  logic [W-1:0] rd_data_o;
  logic         rd_err_o;
  logic         rd_yumi_i;
`ifdef BP_STALL_CTR_OVERFLOW_EN
  logic [R+2:0] overflow_o;
`endif

  int n_pass  = 0;
  int n_total = 0;

  bp_nonsynth_stall_counter_bank #(
    .num_reasons_p(R),
    .ctr_width_p  (W),
    .addr_width_p (A)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .freeze_i      (freeze_i),
    .commit_v_i    (commit_v_i),
    .stall_reason_i(stall_reason_i),
    .rd_v_i        (rd_v_i),
    .rd_addr_i     (rd_addr_i),
    .rd_clear_i    (rd_clear_i),
    .rd_ready_o    (rd_ready_o),
    .rd_v_o        (rd_v_o),
    .rd_data_o     (rd_data_o),
    .rd_err_o      (rd_err_o),
`ifdef BP_STALL_CTR_OVERFLOW_EN
    .overflow_o    (overflow_o),
`endif
    .rd_yumi_i     (rd_yumi_i)
  );

  always #5 clk = ~clk;

  // Stimulus only: issue one read, wait for the response, consume it.
  // Called at posedge+1; events freeze after the accept edge.
  task automatic do_read(input logic [A-1:0] a, input logic c,
                         output logic [W-1:0] d, output logic e);
    bit got = 0;
    rd_v_i = 1'b1; rd_addr_i = a; rd_clear_i = c;
    @(posedge clk); #1;
    rd_v_i = 1'b0; rd_clear_i = 1'b0;
    freeze_i = 1'b1; commit_v_i = 1'b0; stall_reason_i = '0;
    for (int i = 0; i < 8; i++) begin
      if (rd_v_o) begin got = 1; break; end
      @(posedge clk); #1;
    end
    n_total++;
    if (!got) $display("FAIL rd_timeout addr=%0d rd_v_o never rose", a);
    else n_pass++;
    d = rd_data_o; e = rd_err_o;
    rd_yumi_i = 1'b1;
    @(posedge clk); #1;
    rd_yumi_i = 1'b0;
  endtask

  task automatic run_events(input logic cm, input logic [R-1:0] sr,
                            input int n);
    freeze_i = 1'b0; commit_v_i = cm; stall_reason_i = sr;
    repeat (n) @(posedge clk);
    #1;
    freeze_i = 1'b1; commit_v_i = 1'b0; stall_reason_i = '0;
  endtask

  task automatic test_reset();
    logic [W-1:0] d; logic e;
    reset_n_i = 1'b0; freeze_i = 1'b1; commit_v_i = 1'b0;
    stall_reason_i = '0; rd_v_i = 1'b0; rd_addr_i = '0;
    rd_clear_i = 1'b0; rd_yumi_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({rd_ready_o, rd_v_o, rd_err_o} !== 3'b100)
      $display("FAIL reset_flags got=%b exp=100",
               {rd_ready_o, rd_v_o, rd_err_o});
    else n_pass++;
    n_total++;
    if (rd_data_o !== 8'd0)
      $display("FAIL reset_data got=%0d exp=0", rd_data_o);
    else n_pass++;
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    do_read(5'd17, 1'b0, d, e);
    n_total++;
    if (d !== 8'd0) $display("FAIL reset_cycle_ctr got=%0d exp=0", d);
    else n_pass++;
  endtask

  task automatic test_commit();
    logic [W-1:0] d; logic e;
    run_events(1'b1, '0, 10);
    do_read(5'd16, 1'b0, d, e);
    n_total++;
    if (d !== 8'd10) $display("FAIL commit_ctr got=%0d exp=10", d);
    else n_pass++;
    do_read(5'd17, 1'b0, d, e);
    n_total++;
    if (d !== 8'd10) $display("FAIL cycle_ctr got=%0d exp=10", d);
    else n_pass++;
    do_read(5'd18, 1'b0, d, e);
    n_total++;
    if (d !== 8'd0) $display("FAIL unattr_after_commit got=%0d exp=0", d);
    else n_pass++;
  endtask

  task automatic test_stall_reasons();
    logic [W-1:0] d; logic e;
    run_events(1'b0, 16'h0201, 5);
    do_read(5'd0, 1'b0, d, e);
    n_total++;
    if (d !== 8'd5) $display("FAIL reason0 got=%0d exp=5", d);
    else n_pass++;
    do_read(5'd9, 1'b0, d, e);
    n_total++;
    if (d !== 8'd5) $display("FAIL reason9 got=%0d exp=5", d);
    else n_pass++;
    do_read(5'd1, 1'b0, d, e);
    n_total++;
    if (d !== 8'd0) $display("FAIL reason1 got=%0d exp=0", d);
    else n_pass++;
    do_read(5'd18, 1'b0, d, e);
    n_total++;
    if (d !== 8'd0) $display("FAIL unattr got=%0d exp=0", d);
    else n_pass++;
  endtask

  task automatic test_commit_priority();
    logic [W-1:0] d; logic e;
    run_events(1'b1, 16'hFFFF, 1);
    do_read(5'd16, 1'b0, d, e);
    n_total++;
    if (d !== 8'd11) $display("FAIL prio_commit got=%0d exp=11", d);
    else n_pass++;
    do_read(5'd0, 1'b0, d, e);
    n_total++;
    if (d !== 8'd5) $display("FAIL prio_reason0 got=%0d exp=5", d);
    else n_pass++;
    do_read(5'd15, 1'b0, d, e);
    n_total++;
    if (d !== 8'd0) $display("FAIL prio_reason15 got=%0d exp=0", d);
    else n_pass++;
  endtask

  task automatic test_unattributed();
    logic [W-1:0] d; logic e;
    run_events(1'b0, '0, 2);
    do_read(5'd18, 1'b0, d, e);
    n_total++;
    if (d !== 8'd2) $display("FAIL unattr_bubble got=%0d exp=2", d);
    else n_pass++;
    do_read(5'd17, 1'b0, d, e);
    n_total++;
    if (d !== 8'd18) $display("FAIL cycle_total got=%0d exp=18", d);
    else n_pass++;
  endtask

  task automatic test_read_clear();
    logic [W-1:0] d; logic e;
    freeze_i = 1'b0; stall_reason_i = 16'h0008;
    repeat (4) @(posedge clk);
    #1;
    do_read(5'd3, 1'b1, d, e);
    n_total++;
    if (d !== 8'd4) $display("FAIL clear_old got=%0d exp=4", d);
    else n_pass++;
    do_read(5'd3, 1'b0, d, e);
    n_total++;
    if (d !== 8'd1) $display("FAIL clear_new got=%0d exp=1", d);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d; logic e;
    rd_v_i = 1'b1; rd_addr_i = 5'd16; rd_clear_i = 1'b0;
    @(posedge clk); #1;
    rd_v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_v_i = (i == 1); rd_addr_i = 5'd0; rd_clear_i = 1'b1;
      n_total++;
      if ({rd_v_o, rd_ready_o} !== 2'b10)
        $display("FAIL hold_flags cyc=%0d got=%b exp=10", i,
                 {rd_v_o, rd_ready_o});
      else n_pass++;
      n_total++;
      if (rd_data_o !== 8'd11)
        $display("FAIL hold_data cyc=%0d got=%0d exp=11", i, rd_data_o);
      else n_pass++;
      @(posedge clk); #1;
    end
    rd_v_i = 1'b0; rd_clear_i = 1'b0; rd_yumi_i = 1'b1;
    @(posedge clk); #1;
    rd_yumi_i = 1'b0;
    n_total++;
    if ({rd_v_o, rd_ready_o} !== 2'b01)
      $display("FAIL after_yumi got=%b exp=01", {rd_v_o, rd_ready_o});
    else n_pass++;
    do_read(5'd0, 1'b0, d, e);
    n_total++;
    if (d !== 8'd5) $display("FAIL no_reaccept_clear got=%0d exp=5", d);
    else n_pass++;
    do_read(5'd31, 1'b1, d, e);
    n_total++;
    if ({e, d} !== 9'h100)
      $display("FAIL oor31 got err=%b data=%0d exp err=1 data=0", e, d);
    else n_pass++;
    do_read(5'd19, 1'b0, d, e);
    n_total++;
    if ({e, d} !== 9'h100)
      $display("FAIL oor19 got err=%b data=%0d exp err=1 data=0", e, d);
    else n_pass++;
    do_read(5'd18, 1'b0, d, e);
    n_total++;
    if ({e, d} !== 9'h002)
      $display("FAIL inrange18 got err=%b data=%0d exp err=0 data=2", e, d);
    else n_pass++;
  endtask

  task automatic test_yumi_idle();
    rd_yumi_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd_yumi_i = 1'b0;
    n_total++;
    if ({rd_v_o, rd_ready_o} !== 2'b01)
      $display("FAIL yumi_idle got=%b exp=01", {rd_v_o, rd_ready_o});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d; logic e;
    rd_v_i = 1'b1; rd_addr_i = 5'd16; rd_clear_i = 1'b0;
    @(posedge clk); #1;
    rd_v_i = 1'b0;
    n_total++;
    if (rd_v_o !== 1'b1) $display("FAIL mid_resp got=%b exp=1", rd_v_o);
    else n_pass++;
    #2 reset_n_i = 1'b0;
    #1;
    n_total++;
    if ({rd_v_o, rd_ready_o, rd_err_o, rd_data_o} !== {3'b010, 8'd0})
      $display("FAIL mid_reset got v=%b rdy=%b err=%b d=%0d exp 0 1 0 0",
               rd_v_o, rd_ready_o, rd_err_o, rd_data_o);
    else n_pass++;
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    do_read(5'd16, 1'b0, d, e);
    n_total++;
    if (d !== 8'd0) $display("FAIL mid_reset_ctr got=%0d exp=0", d);
    else n_pass++;
  endtask

  task automatic test_saturate();
    logic [W-1:0] d; logic e;
`ifdef BP_STALL_CTR_OVERFLOW_EN
    logic [W-1:0] top = 8'd1;
`else
    logic [W-1:0] top = 8'hFF;
`endif
    run_events(1'b0, 16'h0001, 254);
    do_read(5'd0, 1'b0, d, e);
    n_total++;
    if (d !== 8'hFE) $display("FAIL sat_pre got=%0d exp=254", d);
    else n_pass++;
    run_events(1'b0, 16'h0001, 3);
    do_read(5'd0, 1'b0, d, e);
    n_total++;
    if (d !== top) $display("FAIL sat_reason0 got=%0d exp=%0d", d, top);
    else n_pass++;
    do_read(5'd17, 1'b0, d, e);
    n_total++;
    if (d !== top) $display("FAIL sat_cycle got=%0d exp=%0d", d, top);
    else n_pass++;
`ifdef BP_STALL_CTR_OVERFLOW_EN
    n_total++;
    if (overflow_o !== 19'h20001)
      $display("FAIL ovf_flags got=%h exp=20001", overflow_o);
    else n_pass++;
`endif
    do_read(5'd0, 1'b1, d, e);
    do_read(5'd0, 1'b0, d, e);
    n_total++;
    if (d !== 8'd0) $display("FAIL sat_clear got=%0d exp=0", d);
    else n_pass++;
`ifdef BP_STALL_CTR_OVERFLOW_EN
    n_total++;
    if (overflow_o !== 19'h20000)
      $display("FAIL ovf_clear got=%h exp=20000", overflow_o);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_commit();
    test_stall_reasons();
    test_commit_priority();
    test_unattributed();
    test_read_clear();
    test_back_to_back();
    test_yumi_idle();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
